riscv_muldiv: RTL and testbench
===============================

Name: riscv_muldiv

Overview:
- Iterative multiply/divide unit implementing the RV32M/RV64M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in XLEN and bits retired per cycle.
- Sits beside the single-cycle integer datapath. Decode issues an M-extension op through a valid/ready request; the datapath stalls until the response returns rd/wb for register writeback.
- Adds sequential multi-cycle execution, backpressure and flush, which the combinational datapath does not have.

Parameters:
- XLEN, 32, operand/result width. Legal values: 32 or 64.
- UNROLL, 1, quotient/product bits retired per CALC cycle. Legal values: 1, 2, 4; must divide XLEN.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  abort the in-flight op; no response produced
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept; high only in IDLE with flush low and rst_n high
- req_funct3  in  3  M-op select (instr[14:12])
- req_rs1_value  in  XLEN  operand A
- req_rs2_value  in  XLEN  operand B
- req_rd  in  5  destination register, returned unmodified
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_rd  out  5  destination register
- resp_wb  out  XLEN  result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async on rst_n low): state IDLE; resp_valid=0, resp_rd=0, resp_wb=0, busy=0, req_ready=0 while rst_n low. All internal registers cleared.
- States:
  - IDLE: req_ready=1. On accept (req_valid & req_ready), latch operands, funct3 and rd. Go to DONE if special case, else to CALC.
  - CALC: runs N = XLEN/UNROLL cycles via a step counter. Each cycle retires UNROLL bits (shift-add multiply / restoring divide on magnitudes). After the last step, apply sign fix-up and go to DONE.
  - DONE: resp_valid=1. resp_rd/resp_wb hold stable while resp_ready is low. On resp_valid & resp_ready, go to IDLE; no same-cycle re-accept.
- Latency from accept at cycle T: normal ops assert resp_valid at T+N+1; special cases assert it at T+1.
- Signedness by op:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Core arithmetic operates on absolute values, 2*XLEN-bit product/remainder register.
  - Result negated when operand signs differ (quotient, product) or when the dividend is negative (remainder).
- Result select: MUL gives the low XLEN bits; MULH* give the high XLEN bits; DIV* give the quotient; REM* give the remainder.
- Special cases (decided at accept):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (rs1 = most-negative, rs2 = -1): DIV returns rs1; REM returns 0.
- flush:
  - Any state: next state IDLE; resp_valid deasserts next cycle.
  - Flush in DONE drops the result, even if resp_ready is high that cycle.
  - flush with req_valid in IDLE: not accepted (req_ready low).
- Reset mid-operation: immediate abort to reset values; no stale resp after release.
- Counter width is clog2(N)+1; the counter never wraps within an op.

Decomposition:
- Shared package riscv_pkg:
  - M-op funct3 constants: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - State enum IDLE/CALC/DONE.
  - Opcode constant for the OP class (instr[6:2]=01100) with funct7=0000001 used by decode.
- One sub-module, riscv_muldiv_step: combinational single-bit step (mode mul/div, accumulator, operand) → next accumulator. Instantiated UNROLL times in a chain.

Test Plan (XLEN=32, UNROLL=1, N=32):
- MUL 7 × 0xFFFFFFFD accepted at T → resp_valid at T+33, resp_wb=0xFFFFFFEB, resp_rd echoed; rerun with UNROLL=4 → resp_valid at T+9.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD, REM → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2.
- DIV 0x1234 / 0 → 0xFFFFFFFF at T+1, REM → 0x1234; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1, REM → 0.
- Hold resp_ready low 5 cycles in DONE → resp_wb/resp_rd constant, req_ready=0; release → handshake, IDLE next cycle, req_ready=1.
- Flush at CALC step 10 → no resp_valid ever, busy=0 next cycle, the next op returns the correct result; rst_n pulsed low mid-CALC → all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV M-extension definitions: funct3 op codes, muldiv FSM states and decode constants.
package riscv_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // OP class (instr[6:2]) with funct7 selecting the M extension
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

endpackage

// File: rtl/riscv_muldiv_step.sv
// One bit of shift-add multiply (LSB first) or restoring divide on a {hi,lo} accumulator.
module riscv_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_mode,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN+1:0] diff;

  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    // partial remainder after the shift can need XLEN+1 bits; MSB of diff is the borrow
    diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, opb};
    if (!div_mode)
      acc_nxt = {sum, acc[XLEN-1:1]};
    else if (diff[XLEN+1])
      acc_nxt = {acc[2*XLEN-2:0], 1'b0};
    else
      acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit, UNROLL bits per cycle, valid/ready request and response.
module riscv_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1_value,
  input  logic [XLEN-1:0] req_rs2_value,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_wb,
  output logic            busy
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N) + 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [4:0]        rd_q;
  logic              neg_res;
  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic [XLEN-1:0]   opb, quo, rem, result;

  logic              a_neg, b_neg, is_div, is_rem, div_zero, ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, spec_val;

  assign req_ready = (state == IDLE) && !flush && rst_n;
  assign busy      = (state != IDLE);

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    logic [2*XLEN-1:0] a_in, a_out;
    if (g == 0) begin : g_first
      assign a_in = acc;
    end else begin : g_next
      assign a_in = g_step[g-1].a_out;
    end
    riscv_muldiv_step #(.XLEN(XLEN)) u_step (
      .div_mode(op[2]), .acc(a_in), .opb(opb), .acc_nxt(a_out)
    );
  end
  assign acc_step = g_step[UNROLL-1].a_out;

  // operand decode and special cases, evaluated on the request as offered
  always_comb begin
    is_div   = req_funct3[2];
    is_rem   = req_funct3[2] && req_funct3[1];
    a_neg    = (req_funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && req_rs1_value[XLEN-1];
    b_neg    = (req_funct3 inside {F3_MULH, F3_DIV, F3_REM}) && req_rs2_value[XLEN-1];
    mag_a    = a_neg ? -req_rs1_value : req_rs1_value;
    mag_b    = b_neg ? -req_rs2_value : req_rs2_value;
    div_zero = is_div && (req_rs2_value == '0);
    ovf      = (req_funct3 inside {F3_DIV, F3_REM}) &&
               (req_rs1_value == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2_value == '1);
    special  = div_zero || ovf;
    if (div_zero) spec_val = is_rem ? req_rs1_value : '1;
    else          spec_val = is_rem ? '0 : req_rs1_value;
  end

  // sign fix-up and result select on the final accumulator
  always_comb begin
    prod = neg_res ? -acc_step : acc_step;
    quo  = neg_res ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_res ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op)
      F3_MUL:                       result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result = quo;
      default:                      result = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= '0;
      rd_q       <= '0;
      neg_res    <= 1'b0;
      acc        <= '0;
      opb        <= '0;
      resp_valid <= 1'b0;
      resp_rd    <= '0;
      resp_wb    <= '0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op      <= req_funct3;
          rd_q    <= req_rd;
          neg_res <= is_rem ? a_neg : (a_neg ^ b_neg);
          acc     <= {{XLEN{1'b0}}, mag_a};
          opb     <= mag_b;
          cnt     <= '0;
          if (special) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_wb    <= spec_val;
            resp_rd    <= req_rd;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_wb    <= result;
            resp_rd    <= rd_q;
          end
        end
        DONE: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed-vector bench for riscv_muldiv (XLEN=32, UNROLL=1 plus an UNROLL=4 instance).
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0, req_valid4 = 1'b0;
  logic        req_ready, req_ready4;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1_value = '0, req_rs2_value = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid, resp_valid4;
  logic        resp_ready = 1'b0, resp_ready4 = 1'b1;
  logic [4:0]  resp_rd, resp_rd4;
  logic [31:0] resp_wb, resp_wb4;
  logic        busy, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_muldiv #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1_value(req_rs1_value), .req_rs2_value(req_rs2_value), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
    .resp_wb(resp_wb), .busy(busy)
  );

  riscv_muldiv #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_funct3(req_funct3),
    .req_rs1_value(req_rs1_value), .req_rs2_value(req_rs2_value), .req_rd(req_rd),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_rd(resp_rd4),
    .resp_wb(resp_wb4), .busy(busy4)
  );

  // drive a request on the falling edge; returns #1 after the accepting edge
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    req_funct3 = f3; req_rs1_value = a; req_rs2_value = b; req_rd = rd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // lat counts edges from the accepting edge (inclusive); -1 if no response within the budget
  task automatic wait_resp(output int lat, output logic [31:0] wb, output logic [4:0] rdo);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) lat = -1;
    wb = resp_wb; rdo = resp_rd;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] wb,
                        output logic [4:0] rdo);
    issue(f3, a, b, rd);
    wait_resp(lat, wb, rdo);
    if (lat > 0) consume();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %0b want 0", resp_valid); end
    checks++; if (resp_wb !== 32'h0) begin errors++; $display("FAIL rst_resp_wb got %h want 0", resp_wb); end
    checks++; if (resp_rd !== 5'h0) begin errors++; $display("FAIL rst_resp_rd got %h want 0", resp_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b want 0", req_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_req_ready got %0b want 1", req_ready); end
  endtask

  task automatic test_mul();
    int lat; logic [31:0] wb; logic [4:0] rdo;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, lat, wb, rdo);
    checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
    checks++; if (wb !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_wb got %h want FFFFFFEB", wb); end
    checks++; if (rdo !== 5'd5) begin errors++; $display("FAIL mul_rd got %0d want 5", rdo); end
  endtask

  task automatic test_unroll4();
    int lat;
    @(negedge clk);
    req_funct3 = 3'd0; req_rs1_value = 32'd7; req_rs2_value = 32'hFFFFFFFD; req_rd = 5'd11;
    req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    lat = 1;
    while (!resp_valid4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 9) begin errors++; $display("FAIL unroll4_latency got %0d want 9", lat); end
    checks++; if (resp_wb4 !== 32'hFFFFFFEB) begin errors++; $display("FAIL unroll4_wb got %h want FFFFFFEB", resp_wb4); end
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [2:0]  f3 [10] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd2, 3'd3, 3'd4};
    logic [31:0] a  [10] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'h00000002, 32'h00010000, 32'd100};
    logic [31:0] b  [10] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFF9};
    logic [31:0] ex [10] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'd14, 32'd2, 32'h00000001, 32'h00000001, 32'hFFFFFFF2};
    int lat; logic [31:0] wb; logic [4:0] rdo;
    for (int i = 0; i < 10; i++) begin
      run_op(f3[i], a[i], b[i], 5'(i + 1), lat, wb, rdo);
      checks++; if (wb !== ex[i]) begin errors++; $display("FAIL arith%0d_wb f3=%0d got %h want %h", i, f3[i], wb, ex[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL arith%0d_latency got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3 [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] a  [6] = '{32'h1234, 32'h1234, 32'h55, 32'h55, 32'h80000000, 32'h80000000};
    logic [31:0] b  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex [6] = '{32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 32'h55, 32'h80000000, 32'h0};
    int lat; logic [31:0] wb; logic [4:0] rdo;
    for (int i = 0; i < 6; i++) begin
      run_op(f3[i], a[i], b[i], 5'(20 + i), lat, wb, rdo);
      checks++; if (wb !== ex[i]) begin errors++; $display("FAIL special%0d_wb got %h want %h", i, wb, ex[i]); end
      checks++; if (lat != 1) begin errors++; $display("FAIL special%0d_latency got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] wb; logic [4:0] rdo;
    issue(3'd0, 32'd3, 32'd4, 5'd9);
    wait_resp(lat, wb, rdo);
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_wb !== 32'd12 || resp_rd !== 5'd9 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d valid=%0b wb=%h rd=%0d req_ready=%0b want 1/0000000c/9/0",
                 i, resp_valid, resp_wb, resp_rd, req_ready);
      end
      @(posedge clk); #1;
    end
    consume();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b want 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %0b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_req_ready got %0b want 1", req_ready); end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] wb; logic [4:0] rdo; int seen;
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    repeat (10) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_calc_busy got %0b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_calc_no_resp got %0d valid cycles want 0", seen); end
    // flush while a request is offered in IDLE
    @(negedge clk); flush = 1'b1; req_valid = 1'b1; #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_req_ready got %0b want 0", req_ready); end
    @(posedge clk); #1; flush = 1'b0; req_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %0b want 0", busy); end
    run_op(3'd5, 32'd100, 32'd7, 5'd4, lat, wb, rdo);
    checks++; if (wb !== 32'd14 || lat != 33) begin errors++; $display("FAIL post_flush_op wb=%h lat=%0d want 0000000e/33", wb, lat); end
    // flush in DONE wins over a same-cycle handshake
    issue(3'd4, 32'd5, 32'd0, 5'd6);
    wait_resp(lat, wb, rdo);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_done valid=%0b busy=%0b want 0/0", resp_valid, busy); end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(3'd0, 32'd123, 32'd456, 5'd17);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (resp_valid !== 1'b0 || resp_wb !== 32'h0 || resp_rd !== 5'h0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid valid=%0b wb=%h rd=%0d busy=%0b req_ready=%0b want all 0",
               resp_valid, resp_wb, resp_rd, busy, req_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_stale_resp got %0d valid cycles want 0", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_req_ready got %0b want 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_unroll4();
    test_arith();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
